mem_bus_controller: RTL and testbench

- Sits directly downstream of the CPU core's memory ports and consumes its data port (address, 2-bit mem control, write data) and instruction port (fetch address).
- Arbitrates both ports onto one external asynchronous SRAM bank and a memory-mapped UART byte interface.
- Returns read data and a busy indication to the core.
- Multi-cycle, FSM-sequenced SRAM access with explicit setup/strobe/hold phases for writes.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_bus_controller_uart.sv | 47 ++++
 rtl/mem_bus_controller.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mem_bus_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory bus controller and its UART register port.
package mem_pkg;

    // Controller sequencing states; every state except IDLE reports busy.
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        UART_WAIT,
        UART_RESP
    } busStateT;

    // Data-port control encodings; 2'b11 is reserved and treated as no request.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10,
        MEM_RSVD  = 2'b11
    } memCtrlT;

    localparam logic [15:0] DEF_UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] DEF_UART_STAT_ADDR = 16'hBF01;

    // Bit positions inside the UART status word.
    localparam int unsigned STAT_TX_READY_BIT = 0;
    localparam int unsigned STAT_RX_VALID_BIT = 1;

endpackage

// File: rtl/mem_bus_controller_uart.sv
// UART register window: address decode, read-data formatting and tx/ack intents.
// Purely combinational; the controller registers whatever it accepts.
module uart_reg_port
    import mem_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 16,
    parameter int unsigned       DATA_W         = 16,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = ADDR_W'(DEF_UART_DATA_ADDR),
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = ADDR_W'(DEF_UART_STAT_ADDR)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              isWrite,
    input  logic [7:0]        wByte,
    input  logic              txReady,
    input  logic [7:0]        rxData,
    input  logic              rxValid,
    output logic              hit,
    output logic              holdOff,
    output logic [DATA_W-1:0] rdata,
    output logic              txFire,
    output logic [7:0]        txByte,
    output logic              rxAck
);

    logic isData;
    logic isStat;

    // Decode the window and derive what an access at this address would do right now.
    always_comb begin
        isData  = (addr == UART_DATA_ADDR);
        isStat  = (addr == UART_STAT_ADDR);
        hit     = isData || isStat;
        holdOff = isData && isWrite && !txReady;
        txFire  = isData && isWrite && txReady;
        txByte  = wByte;
        // A data read without a pending byte returns the stale byte and does not ack.
        rxAck   = isData && !isWrite && rxValid;
        rdata   = '0;
        if (isStat) begin
            rdata[STAT_TX_READY_BIT] = txReady;
            rdata[STAT_RX_VALID_BIT] = rxValid;
        end else begin
            rdata[7:0] = rxData;
        end
    end

endmodule

// File: rtl/mem_bus_controller.sv
// Arbitrates the CPU data and instruction ports onto an async SRAM and a UART register window.
// Every output is registered; the next-state block computes the value each output takes
// on entry to the next state.
module mem_bus_controller
    import mem_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 16,
    parameter int unsigned       DATA_W         = 16,
    parameter int unsigned       SRAM_ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = ADDR_W'(DEF_UART_DATA_ADDR),
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = ADDR_W'(DEF_UART_STAT_ADDR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic [1:0]             d_ctrl,
    input  logic [DATA_W-1:0]      d_wdata,
    output logic [DATA_W-1:0]      d_rdata,
    output logic                   d_valid,
    input  logic                   i_req,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [DATA_W-1:0]      i_rdata,
    output logic                   i_valid,
    output logic                   busy,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [DATA_W-1:0]      sram_dq_in,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_valid,
    input  logic                   uart_tx_ready,
    input  logic [7:0]             uart_rx_data,
    input  logic                   uart_rx_valid,
    output logic                   uart_rx_ack
);

    busStateT state;
    busStateT stateNext;

    logic [ADDR_W-1:0] latAddr;
    logic [7:0]        latByte;
    logic              latFetch;

    logic              dReq;
    logic              dWrite;
    logic [ADDR_W-1:0] uAddr;
    logic              uWrite;
    logic [7:0]        uByte;

    logic              uHit;
    logic              uHold;
    logic [DATA_W-1:0] uRdata;
    logic              uTxFire;
    logic [7:0]        uTxByte;
    logic              uRxAck;

    logic                   ceNext;
    logic                   oeNext;
    logic                   weNext;
    logic                   dqOeNext;
    logic [SRAM_ADDR_W-1:0] addrNext;
    logic [DATA_W-1:0]      dqOutNext;
    logic [DATA_W-1:0]      dRdataNext;
    logic [DATA_W-1:0]      iRdataNext;
    logic                   dValidNext;
    logic                   iValidNext;
    logic                   txValidNext;
    logic [7:0]             txDataNext;
    logic                   rxAckNext;

    // Request decode; outside IDLE the UART port sees the request latched at acceptance.
    always_comb begin
        dReq   = (d_ctrl == MEM_READ) || (d_ctrl == MEM_WRITE);
        dWrite = (d_ctrl == MEM_WRITE);
        if (state == IDLE) begin
            uAddr  = d_addr;
            uWrite = dWrite;
            uByte  = d_wdata[7:0];
        end else begin
            uAddr  = latAddr;
            uWrite = 1'b1;
            uByte  = latByte;
        end
    end

    uart_reg_port #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .UART_DATA_ADDR (UART_DATA_ADDR),
        .UART_STAT_ADDR (UART_STAT_ADDR)
    ) uUartPort (
        .addr    (uAddr),
        .isWrite (uWrite),
        .wByte   (uByte),
        .txReady (uart_tx_ready),
        .rxData  (uart_rx_data),
        .rxValid (uart_rx_valid),
        .hit     (uHit),
        .holdOff (uHold),
        .rdata   (uRdata),
        .txFire  (uTxFire),
        .txByte  (uTxByte),
        .rxAck   (uRxAck)
    );

    // Capture the accepted request so later states do not depend on the port staying stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latAddr  <= '0;
            latByte  <= '0;
            latFetch <= 1'b0;
        end else if (state == IDLE) begin
            latAddr  <= d_addr;
            latByte  <= d_wdata[7:0];
            latFetch <= !dReq;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and the registered output values that go with it.
    always_comb begin
        stateNext   = state;
        ceNext      = 1'b1;
        oeNext      = 1'b1;
        weNext      = 1'b1;
        dqOeNext    = 1'b0;
        addrNext    = sram_addr;
        dqOutNext   = sram_dq_out;
        dRdataNext  = d_rdata;
        iRdataNext  = i_rdata;
        dValidNext  = 1'b0;
        iValidNext  = 1'b0;
        txValidNext = 1'b0;
        txDataNext  = uart_tx_data;
        rxAckNext   = 1'b0;
        unique case (state)
            IDLE: begin
                if (dReq) begin
                    if (uHit) begin
                        if (uHold) begin
                            stateNext = UART_WAIT;
                        end else begin
                            stateNext  = UART_RESP;
                            dValidNext = 1'b1;
                            if (!dWrite) begin
                                dRdataNext = uRdata;
                            end
                            txValidNext = uTxFire;
                            if (uTxFire) begin
                                txDataNext = uTxByte;
                            end
                            rxAckNext = uRxAck;
                        end
                    end else if (dWrite) begin
                        stateNext = WR_SETUP;
                        addrNext  = SRAM_ADDR_W'(d_addr);
                        dqOutNext = d_wdata;
                        dqOeNext  = 1'b1;
                        ceNext    = 1'b0;
                    end else begin
                        stateNext = RD;
                        addrNext  = SRAM_ADDR_W'(d_addr);
                        ceNext    = 1'b0;
                        oeNext    = 1'b0;
                    end
                end else if (i_req) begin
                    stateNext = RD;
                    addrNext  = SRAM_ADDR_W'(i_addr);
                    ceNext    = 1'b0;
                    oeNext    = 1'b0;
                end
            end
            RD: begin
                stateNext = IDLE;
                if (latFetch) begin
                    iRdataNext = sram_dq_in;
                    iValidNext = 1'b1;
                end else begin
                    dRdataNext = sram_dq_in;
                    dValidNext = 1'b1;
                end
            end
            WR_SETUP: begin
                stateNext = WR_PULSE;
                ceNext    = 1'b0;
                weNext    = 1'b0;
                dqOeNext  = 1'b1;
            end
            WR_PULSE: begin
                stateNext  = WR_HOLD;
                ceNext     = 1'b0;
                dqOeNext   = 1'b1;
                dValidNext = 1'b1;
            end
            WR_HOLD: begin
                stateNext = IDLE;
            end
            UART_WAIT: begin
                if (!uHold) begin
                    stateNext   = UART_RESP;
                    dValidNext  = 1'b1;
                    txValidNext = uTxFire;
                    if (uTxFire) begin
                        txDataNext = uTxByte;
                    end
                end
            end
            UART_RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output registers; async reset drops every strobe and drive enable immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_dq_oe    <= 1'b0;
            sram_addr     <= '0;
            sram_dq_out   <= '0;
            d_rdata       <= '0;
            i_rdata       <= '0;
            d_valid       <= 1'b0;
            i_valid       <= 1'b0;
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
            uart_rx_ack   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            sram_ce_n     <= ceNext;
            sram_oe_n     <= oeNext;
            sram_we_n     <= weNext;
            sram_dq_oe    <= dqOeNext;
            sram_addr     <= addrNext;
            sram_dq_out   <= dqOutNext;
            d_rdata       <= dRdataNext;
            i_rdata       <= iRdataNext;
            d_valid       <= dValidNext;
            i_valid       <= iValidNext;
            uart_tx_valid <= txValidNext;
            uart_tx_data  <= txDataNext;
            uart_rx_ack   <= rxAckNext;
            busy          <= (stateNext != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Self-checking bench for mem_bus_controller with an SRAM model and a transaction-level memory reference.
module tb_mem_bus_controller;

    logic        clk;
    logic        rst;
    logic [15:0] d_addr;
    logic [1:0]  d_ctrl;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_valid;
    logic        busy;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ack;

    int nChecks = 0;
    int nFails  = 0;

    // Monitor counters, sampled mid-cycle.
    int dValidCnt = 0;
    int iValidCnt = 0;
    int txValidCnt = 0;
    int rxAckCnt = 0;
    int ceLowCnt = 0;
    int weLowCnt = 0;
    int conflictCnt = 0;
    int highAddrCnt = 0;

    // Reference contents of SRAM as seen by completed CPU writes.
    logic [15:0] refMem [logic [15:0]];

    // Asynchronous SRAM model.
    logic [15:0] sramMem [0:65535] = '{default: 16'h0000};

    mem_bus_controller #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .SRAM_ADDR_W    (18),
        .UART_DATA_ADDR (16'hBF00),
        .UART_STAT_ADDR (16'hBF01)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .d_addr        (d_addr),
        .d_ctrl        (d_ctrl),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_valid       (d_valid),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_rdata       (i_rdata),
        .i_valid       (i_valid),
        .busy          (busy),
        .sram_addr     (sram_addr),
        .sram_dq_out   (sram_dq_out),
        .sram_dq_oe    (sram_dq_oe),
        .sram_dq_in    (sram_dq_in),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ack   (uart_rx_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sramMem[sram_addr[15:0]] : 16'hDEAD;

    // SRAM write commit and bus monitor, both mid-cycle.
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) sramMem[sram_addr[15:0]] <= sram_dq_out;
        if (d_valid) dValidCnt++;
        if (i_valid) iValidCnt++;
        if (uart_tx_valid) txValidCnt++;
        if (uart_rx_ack) rxAckCnt++;
        if (!sram_ce_n) ceLowCnt++;
        if (!sram_we_n) weLowCnt++;
        if (!sram_ce_n && !sram_oe_n && sram_dq_oe) conflictCnt++;
        if (sram_addr[17:16] != 2'b00) highAddrCnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic dataAccess(input logic isWrite, input logic [15:0] addr, input logic [15:0] wdata,
                              output logic [15:0] rdata, output int lat);
        d_ctrl = isWrite ? 2'b10 : 2'b01;
        d_addr = addr;
        d_wdata = wdata;
        lat = -1;
        rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (d_valid) begin
                lat = c;
                rdata = d_rdata;
                break;
            end
        end
        d_ctrl = 2'b00;
        // An SRAM write still has its hold cycle to finish.
        if (isWrite && lat == 3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic fetchAccess(input logic [15:0] addr, output logic [15:0] rdata, output int lat);
        i_req = 1'b1;
        i_addr = addr;
        lat = -1;
        rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (i_valid) begin
                lat = c;
                rdata = i_rdata;
                break;
            end
        end
        i_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL reset_busy: got %b want 0", busy); end
        nChecks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin nFails++;
            $display("FAIL reset_strobes: got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}); end
        nChecks++; if ({sram_addr, sram_dq_out, d_rdata, i_rdata} !== 66'd0) begin nFails++;
            $display("FAIL reset_data: got %h %h %h %h want zeros", sram_addr, sram_dq_out, d_rdata, i_rdata); end
        nChecks++; if ({d_valid, i_valid, uart_tx_valid, uart_rx_ack} !== 4'b0000) begin nFails++;
            $display("FAIL reset_pulses: got %b want 0000", {d_valid, i_valid, uart_tx_valid, uart_rx_ack}); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_read();
        logic [15:0] rd;
        int lat;
        int w0;
        w0 = weLowCnt;
        d_ctrl = 2'b10; d_addr = 16'h0040; d_wdata = 16'h1234;
        @(posedge clk); #1;
        nChecks++; if ({sram_ce_n, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out} !== {1'b0, 1'b1, 1'b1, 18'h00040, 16'h1234}) begin nFails++;
            $display("FAIL wr_setup: got ce%b we%b oe%b a=%h d=%h want ce0 we1 oe1 a=00040 d=1234",
                     sram_ce_n, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out); end
        @(posedge clk); #1;
        nChecks++; if ({sram_ce_n, sram_we_n, sram_dq_oe, d_valid} !== 4'b0010) begin nFails++;
            $display("FAIL wr_pulse: got %b want 0010", {sram_ce_n, sram_we_n, sram_dq_oe, d_valid}); end
        @(posedge clk); #1;
        nChecks++; if ({sram_we_n, sram_dq_oe, d_valid} !== 3'b111) begin nFails++;
            $display("FAIL wr_hold: got %b want 111", {sram_we_n, sram_dq_oe, d_valid}); end
        d_ctrl = 2'b00;
        refMem[16'h0040] = 16'h1234;
        @(posedge clk); #1;
        nChecks++; if ({sram_ce_n, sram_dq_oe, busy, d_valid} !== 4'b1000) begin nFails++;
            $display("FAIL wr_release: got %b want 1000", {sram_ce_n, sram_dq_oe, busy, d_valid}); end
        nChecks++; if (weLowCnt - w0 !== 1) begin nFails++;
            $display("FAIL we_width: got %0d cycles want 1", weLowCnt - w0); end
        dataAccess(1'b0, 16'h0040, 16'h0000, rd, lat);
        nChecks++; if (lat !== 2) begin nFails++; $display("FAIL rd_latency: got %0d want 2", lat); end
        nChecks++; if (rd !== 16'h1234) begin nFails++; $display("FAIL rd_data: got %h want 1234", rd); end
    endtask

    task automatic test_arbitration();
        logic [15:0] a, b, rd;
        int lat, dCyc, iCyc, busyBad, c0;
        a = 16'($urandom); b = 16'($urandom);
        dataAccess(1'b1, 16'h0010, a, rd, lat); refMem[16'h0010] = a;
        dataAccess(1'b1, 16'h0020, b, rd, lat); refMem[16'h0020] = b;
        c0 = conflictCnt;
        dCyc = -1; iCyc = -1; busyBad = 0;
        d_ctrl = 2'b01; d_addr = 16'h0010; i_req = 1'b1; i_addr = 16'h0020;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if ((c == 1 || c == 3) && !busy) busyBad++;
            if (d_valid) begin dCyc = c; rd = d_rdata; d_ctrl = 2'b00; end
            if (i_valid) begin iCyc = c; i_req = 1'b0; break; end
        end
        i_req = 1'b0; d_ctrl = 2'b00;
        nChecks++; if (dCyc !== 2) begin nFails++; $display("FAIL arb_d_cycle: got %0d want 2", dCyc); end
        nChecks++; if (iCyc !== 4) begin nFails++; $display("FAIL arb_i_cycle: got %0d want 4", iCyc); end
        nChecks++; if (rd !== refMem[16'h0010]) begin nFails++; $display("FAIL arb_d_data: got %h want %h", rd, refMem[16'h0010]); end
        nChecks++; if (i_rdata !== refMem[16'h0020]) begin nFails++; $display("FAIL arb_i_data: got %h want %h", i_rdata, refMem[16'h0020]); end
        nChecks++; if (busyBad !== 0) begin nFails++; $display("FAIL arb_busy: %0d cycles low, want 0", busyBad); end
        nChecks++; if (conflictCnt - c0 !== 0) begin nFails++; $display("FAIL arb_bus_conflict: got %0d want 0", conflictCnt - c0); end
    endtask

    task automatic test_random_sram();
        logic [15:0] pool [6];
        logic [15:0] rd, a, w, exp;
        int lat, kind;
        for (int i = 0; i < 6; i++) begin
            pool[i] = 16'($urandom);
            if (pool[i] == 16'hBF00 || pool[i] == 16'hBF01) pool[i] = 16'h0100 + 16'(i);
        end
        for (int n = 0; n < 30; n++) begin
            a = pool[$urandom_range(0, 5)];
            kind = $urandom_range(0, 2);
            exp = refMem.exists(a) ? refMem[a] : 16'h0000;
            if (kind == 0) begin
                w = 16'($urandom);
                dataAccess(1'b1, a, w, rd, lat);
                refMem[a] = w;
                nChecks++; if (lat !== 3) begin nFails++; $display("FAIL rnd_wr_latency: addr %h got %0d want 3", a, lat); end
            end else if (kind == 1) begin
                dataAccess(1'b0, a, 16'h0000, rd, lat);
                nChecks++; if (lat !== 2 || rd !== exp) begin nFails++;
                    $display("FAIL rnd_rd: addr %h got lat %0d data %h want lat 2 data %h", a, lat, rd, exp); end
            end else begin
                fetchAccess(a, rd, lat);
                nChecks++; if (lat !== 2 || rd !== exp) begin nFails++;
                    $display("FAIL rnd_fetch: addr %h got lat %0d data %h want lat 2 data %h", a, lat, rd, exp); end
            end
        end
        nChecks++; if (highAddrCnt !== 0) begin nFails++; $display("FAIL sram_upper_bits: got %0d nonzero cycles want 0", highAddrCnt); end
    endtask

    task automatic test_uart_read();
        logic [15:0] rd, exp;
        int lat, a0, c0;
        c0 = ceLowCnt;
        for (int k = 0; k < 4; k++) begin
            uart_rx_valid = k[1];
            uart_tx_ready = k[0];
            uart_rx_data = 8'($urandom);
            a0 = rxAckCnt;
            exp = 16'(k[1]) * 16'd2 + 16'(k[0]);
            dataAccess(1'b0, 16'hBF01, 16'h0000, rd, lat);
            @(posedge clk); #1;
            nChecks++; if (lat !== 1 || rd !== exp || rxAckCnt - a0 !== 0) begin nFails++;
                $display("FAIL uart_status: rx%0d tx%0d got lat %0d data %h acks %0d want lat 1 data %h acks 0",
                         k[1], k[0], lat, rd, rxAckCnt - a0, exp); end
        end
        uart_rx_valid = 1'b1; uart_tx_ready = 1'b0; uart_rx_data = 8'($urandom);
        a0 = rxAckCnt;
        dataAccess(1'b0, 16'hBF00, 16'h0000, rd, lat);
        @(posedge clk); #1;
        nChecks++; if (lat !== 1 || rd !== {8'h00, uart_rx_data}) begin nFails++;
            $display("FAIL uart_rx_data: got lat %0d data %h want lat 1 data %h", lat, rd, {8'h00, uart_rx_data}); end
        nChecks++; if (rxAckCnt - a0 !== 1) begin nFails++; $display("FAIL uart_rx_ack: got %0d pulses want 1", rxAckCnt - a0); end
        uart_rx_valid = 1'b0; uart_rx_data = 8'($urandom);
        a0 = rxAckCnt;
        dataAccess(1'b0, 16'hBF00, 16'h0000, rd, lat);
        @(posedge clk); #1;
        nChecks++; if (rd !== {8'h00, uart_rx_data} || rxAckCnt - a0 !== 0) begin nFails++;
            $display("FAIL uart_rx_stale: got data %h acks %0d want data %h acks 0", rd, rxAckCnt - a0, {8'h00, uart_rx_data}); end
        nChecks++; if (ceLowCnt - c0 !== 0) begin nFails++; $display("FAIL uart_rd_sram_idle: got %0d ce cycles want 0", ceLowCnt - c0); end
    endtask

    task automatic test_uart_write();
        logic [15:0] rd;
        logic [7:0] b;
        int lat, t0, v0, c0, busyBad;
        c0 = ceLowCnt; t0 = txValidCnt; v0 = dValidCnt; busyBad = 0;
        uart_tx_ready = 1'b0;
        d_ctrl = 2'b10; d_addr = 16'hBF00; d_wdata = 16'h0041;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (!busy) busyBad++;
        end
        nChecks++; if (busyBad !== 0) begin nFails++; $display("FAIL uart_wait_busy: %0d cycles low want 0", busyBad); end
        nChecks++; if (txValidCnt - t0 !== 0 || dValidCnt - v0 !== 0) begin nFails++;
            $display("FAIL uart_wait_early: got tx %0d dvalid %0d want 0 0", txValidCnt - t0, dValidCnt - v0); end
        uart_tx_ready = 1'b1;
        @(posedge clk); #1;
        nChecks++; if ({uart_tx_valid, d_valid, uart_tx_data} !== {1'b1, 1'b1, 8'h41}) begin nFails++;
            $display("FAIL uart_wait_release: got txv%b dv%b data %h want txv1 dv1 data 41", uart_tx_valid, d_valid, uart_tx_data); end
        d_ctrl = 2'b00;
        @(posedge clk); #1;
        nChecks++; if ({uart_tx_valid, busy} !== 2'b00 || txValidCnt - t0 !== 1) begin nFails++;
            $display("FAIL uart_tx_single: got txv%b busy%b pulses %0d want 0 0 1", uart_tx_valid, busy, txValidCnt - t0); end
        b = 8'($urandom);
        t0 = txValidCnt;
        dataAccess(1'b1, 16'hBF00, {8'($urandom), b}, rd, lat);
        nChecks++; if (lat !== 1 || uart_tx_data !== b || uart_tx_valid !== 1'b1) begin nFails++;
            $display("FAIL uart_tx_ready_write: got lat %0d data %h txv %b want lat 1 data %h txv 1", lat, uart_tx_data, uart_tx_valid, b); end
        @(posedge clk); #1;
        t0 = txValidCnt;
        dataAccess(1'b1, 16'hBF01, 16'($urandom), rd, lat);
        @(posedge clk); #1;
        nChecks++; if (lat !== 1 || txValidCnt - t0 !== 0) begin nFails++;
            $display("FAIL uart_status_write: got lat %0d tx %0d want lat 1 tx 0", lat, txValidCnt - t0); end
        nChecks++; if (ceLowCnt - c0 !== 0) begin nFails++; $display("FAIL uart_wr_sram_idle: got %0d ce cycles want 0", ceLowCnt - c0); end
    endtask

    task automatic test_ctrl_reserved();
        int v0, busyBad;
        v0 = dValidCnt + iValidCnt + ceLowCnt + txValidCnt + rxAckCnt;
        busyBad = 0;
        d_ctrl = 2'b11; d_addr = 16'h0040; i_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (busy) busyBad++;
        end
        d_ctrl = 2'b00;
        nChecks++; if (busyBad !== 0) begin nFails++; $display("FAIL ctrl11_busy: got %0d busy cycles want 0", busyBad); end
        nChecks++; if (dValidCnt + iValidCnt + ceLowCnt + txValidCnt + rxAckCnt - v0 !== 0) begin nFails++;
            $display("FAIL ctrl11_activity: got %0d events want 0", dValidCnt + iValidCnt + ceLowCnt + txValidCnt + rxAckCnt - v0); end
    endtask

    task automatic test_reset_mid_write();
        int v0;
        logic found;
        found = 1'b0;
        d_ctrl = 2'b10; d_addr = 16'h7777; d_wdata = 16'hBEEF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!sram_we_n) begin found = 1'b1; break; end
        end
        nChecks++; if (found !== 1'b1) begin nFails++; $display("FAIL midwr_reach_pulse: got %b want 1", found); end
        v0 = dValidCnt;
        rst = 1'b0;
        #1;
        nChecks++; if ({sram_we_n, sram_dq_oe, sram_ce_n, busy} !== 4'b1010) begin nFails++;
            $display("FAIL midwr_async_release: got %b want 1010", {sram_we_n, sram_dq_oe, sram_ce_n, busy}); end
        d_ctrl = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        nChecks++; if (busy !== 1'b0 || dValidCnt - v0 !== 0) begin nFails++;
            $display("FAIL midwr_after: got busy %b dvalid %0d want 0 0", busy, dValidCnt - v0); end
    endtask

    initial begin
        rst = 1'b1;
        d_addr = '0; d_ctrl = 2'b00; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        uart_tx_ready = 1'b1; uart_rx_data = '0; uart_rx_valid = 1'b0;
        test_reset();
        test_write_read();
        test_arbitration();
        test_random_sram();
        test_uart_read();
        test_uart_write();
        test_ctrl_reserved();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
